// File: rtl/timer_pkg.sv
// timer_pkg: shared types and constants for the timer_dev peripheral.
// States, register offsets, mode encodings and CTRL bit positions.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] CTRL_OFF   = 2'd0;
    localparam logic [1:0] PRESET_OFF = 2'd1;
    localparam logic [1:0] COUNT_OFF  = 2'd2;
    localparam logic [1:0] PSC_OFF    = 2'd3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: tick once every div+1 cycles.
// The phase is reset by restart so each period starts aligned.
module timer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt_q;

    // >= keeps the divider sane if div is lowered mid-period
    assign tick = (cnt_q >= div);

    // Divider phase counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (restart || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer driving one CP0 HWint line.
// Optional TIMER_PRESCALE_EN adds the PSC register at offset 0xC.
module timer_dev
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_t           state_q, state_d;
    logic             ctrl_en, ctrl_im;
    logic [1:0]       ctrl_mode;
    logic [CNT_W-1:0] preset, count_q, count_d;
    logic             irq_flag;
    logic             hit, wr_hit, ctrl_wr;
    logic             set_flag, clr_flag, clr_en, restart;
    logic             tick;
    logic [31:0]      psc_rd;
    logic             unused_bits;

    assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_hit  = we && hit;
    assign ctrl_wr = wr_hit && (addr[3:2] == CTRL_OFF);

    // Flag and IM are both registers, so irq never sees the bus directly
    assign irq = irq_flag && ctrl_im;

`ifdef TIMER_PRESCALE_EN
    logic [15:0] psc_q;

    // Prescaler divisor register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_q <= '0;
        end else if (wr_hit && (addr[3:2] == PSC_OFF)) begin
            psc_q <= wdata[15:0];
        end
    end

    timer_prescaler u_psc (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .div     (psc_q),
        .tick    (tick)
    );

    assign psc_rd      = {16'd0, psc_q};
    assign unused_bits = ^addr[1:0];
`else
    assign tick        = 1'b1;
    assign psc_rd      = '0;
    assign unused_bits = ^{addr[1:0], restart};
`endif

    // State and counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state, count update and side-effect strobes
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        set_flag = 1'b0;
        clr_flag = 1'b0;
        clr_en   = 1'b0;
        restart  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ctrl_en) state_d = LOAD;
            end
            LOAD: begin
                count_d = preset;
                restart = 1'b1;
                state_d = CNT;
            end
            CNT: begin
                if (!ctrl_en) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (count_q > CNT_W'(1)) begin
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        count_d  = '0;
                        set_flag = 1'b1;
                        state_d  = INT;
                    end
                end
            end
            INT: begin
                if (ctrl_mode == MODE_RELOAD) begin
                    clr_flag = 1'b1;
                    state_d  = LOAD;
                end else begin
                    clr_en  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // CTRL register; a bus write beats the one-shot En clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= MODE_ONESHOT;
            ctrl_im   <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl_en   <= wdata[CTRL_EN_BIT];
            ctrl_mode <= wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
            ctrl_im   <= wdata[CTRL_IM_BIT];
        end else if (clr_en) begin
            ctrl_en   <= 1'b0;
        end
    end

    // PRESET register; only sampled by the FSM in LOAD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= '0;
        end else if (wr_hit && (addr[3:2] == PRESET_OFF)) begin
            preset <= wdata[CNT_W-1:0];
        end
    end

    // Interrupt flag; any CTRL write acknowledges it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_flag <= 1'b0;
        end else if (ctrl_wr) begin
            irq_flag <= 1'b0;
        end else if (set_flag) begin
            irq_flag <= 1'b1;
        end else if (clr_flag) begin
            irq_flag <= 1'b0;
        end
    end

    // Combinational read mux
    always_comb begin
        rdata = '0;
        if (hit) begin
            unique case (addr[3:2])
                CTRL_OFF:   rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
                PRESET_OFF: rdata = 32'(preset);
                COUNT_OFF:  rdata = 32'(count_q);
                PSC_OFF:    rdata = psc_rd;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed self-checking bench for timer_dev.
// Covers reset, one-shot, auto-reload, PRESET update, decode, prescaler.
module tb_timer_dev;

    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_PRE  = BASE + 32'h4;
    localparam logic [31:0] A_CNT  = BASE + 32'h8;
    localparam logic [31:0] A_PSC  = BASE + 32'hC;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks;
    int errors;

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller sits in the low phase; the write commits at the next posedge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [31:0] regs [3];
        regs[0] = A_CTRL;
        regs[1] = A_PRE;
        regs[2] = A_CNT;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            rd(regs[i], d);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL por_reg%0d got %h want 0", i, d);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL por_irq got %b want 0", irq);
        end
        @(negedge clk);
        reset = 1'b1;
        wait_n(2);
    endtask

    task automatic test_reset_midcount;
        logic [31:0] d;
        wr(A_PRE, 32'd100);
        wr(A_CTRL, 32'h1);
        wait_n(20);
        rd(A_CNT, d);
        checks++;
        if (d !== 32'd82) begin
            errors++;
            $display("FAIL midcnt_count got %0d want 82", d);
        end
        #1;
        reset = 1'b0;
        #1;
        rd(A_CNT, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rst_count got %0d want 0", d);
        end
        rd(A_PRE, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rst_preset got %0d want 0", d);
        end
        rd(A_CTRL, d);
        checks++;
        if (d !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_ctrl got %h irq %b want 0 0", d, irq);
        end
        @(negedge clk);
        reset = 1'b1;
        wr(A_PRE, 32'd7);
        wait_n(4);
        rd(A_CNT, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rst_idle_count got %0d want 0", d);
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] d;
        wr(A_PRE, 32'd5);
        wr(A_CTRL, 32'h9);
        wait_n(2);
        rd(A_CNT, d);
        checks++;
        if (d !== 32'd5) begin
            errors++;
            $display("FAIL os_count_e2 got %0d want 5", d);
        end
        wait_n(4);
        rd(A_CNT, d);
        checks++;
        if (d !== 32'd1 || irq !== 1'b0) begin
            errors++;
            $display("FAIL os_e6 got cnt %0d irq %b want 1 0", d, irq);
        end
        wait_n(1);
        rd(A_CNT, d);
        checks++;
        if (d !== 32'd0 || irq !== 1'b1) begin
            errors++;
            $display("FAIL os_e7 got cnt %0d irq %b want 0 1", d, irq);
        end
        wait_n(1);
        rd(A_CTRL, d);
        checks++;
        if (d !== 32'h8) begin
            errors++;
            $display("FAIL os_ctrl_e8 got %h want 8", d);
        end
        wait_n(3);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL os_irq_hold got %b want 1", irq);
        end
        wr(A_CTRL, 32'h8);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL os_ack got %b want 0", irq);
        end
    endtask

    task automatic test_reload;
        logic [31:0] d;
        logic        exp_irq;
        logic [31:0] exp_cnt [11];
        exp_cnt = '{3, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0};
        wr(A_PRE, 32'd3);
        wr(A_CTRL, 32'hB);
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            exp_irq = (k >= 5) && ((k - 5) % 5 == 0);
            checks++;
            if (irq !== exp_irq) begin
                errors++;
                $display("FAIL ar_irq e%0d got %b want %b", k, irq, exp_irq);
            end
        end
        wr(A_CTRL, 32'h0);
        wait_n(1);
        wr(A_CTRL, 32'h3);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            rd(A_CNT, d);
            checks++;
            if (d !== exp_cnt[k-1] || irq !== 1'b0) begin
                errors++;
                $display("FAIL ar_noim e%0d got cnt %0d irq %b want %0d 0",
                         k, d, irq, exp_cnt[k-1]);
            end
        end
        wr(A_CTRL, 32'h0);
        wait_n(1);
    endtask

    task automatic test_preset_update;
        logic [31:0] d;
        logic        exp_irq;
        wr(A_PRE, 32'd10);
        wr(A_CTRL, 32'hB);
        wait_n(6);
        rd(A_CNT, d);
        checks++;
        if (d !== 32'd6) begin
            errors++;
            $display("FAIL pu_count_e6 got %0d want 6", d);
        end
        wr(A_PRE, 32'd2);
        rd(A_CNT, d);
        checks++;
        if (d !== 32'd5) begin
            errors++;
            $display("FAIL pu_count_e7 got %0d want 5", d);
        end
        for (int k = 8; k <= 21; k++) begin
            @(negedge clk);
            exp_irq = (k == 12) || (k == 16) || (k == 20);
            checks++;
            if (irq !== exp_irq) begin
                errors++;
                $display("FAIL pu_irq e%0d got %b want %b", k, irq, exp_irq);
            end
        end
        wr(A_CTRL, 32'h0);
        wait_n(2);
    endtask

    task automatic test_decode;
        logic [31:0] d;
        logic [31:0] exp_psc;
        wr(A_CNT, 32'hFFFF);
        rd(A_CNT, d);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL dec_count_ro got %h want 2", d);
        end
        wr(BASE + 32'h10, 32'hF);
        wr(BASE + 32'h14, 32'h55);
        wait_n(4);
        rd(A_CTRL, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL dec_miss_ctrl got %h want 0", d);
        end
        rd(A_PRE, d);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL dec_miss_preset got %h want 2", d);
        end
        rd(A_CNT, d);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL dec_miss_count got %h want 2", d);
        end
        rd(BASE + 32'h14, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL dec_miss_read got %h want 0", d);
        end
        wr(A_CTRL, 32'hFFFF_FFF8);
        rd(A_CTRL, d);
        checks++;
        if (d !== 32'h8) begin
            errors++;
            $display("FAIL dec_ctrl_mask got %h want 8", d);
        end
        wr(A_CTRL, 32'h0);
        wr(A_PSC, 32'h1234);
`ifdef TIMER_PRESCALE_EN
        exp_psc = 32'h1234;
`else
        exp_psc = 32'h0;
`endif
        rd(A_PSC, d);
        checks++;
        if (d !== exp_psc) begin
            errors++;
            $display("FAIL dec_psc got %h want %h", d, exp_psc);
        end
        wr(A_PSC, 32'h0);
    endtask

`ifdef TIMER_PRESCALE_EN
    task automatic test_prescale;
        logic exp_irq;
        wr(A_PSC, 32'd3);
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_irq = (k >= 10);
            checks++;
            if (irq !== exp_irq) begin
                errors++;
                $display("FAIL psc_irq e%0d got %b want %b", k, irq, exp_irq);
            end
        end
        wr(A_CTRL, 32'h0);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL psc_ack got %b want 0", irq);
        end
        wr(A_PSC, 32'h0);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        addr   = '0;
        we     = 1'b0;
        wdata  = '0;
        reset  = 1'b0;
        test_reset;
        test_reset_midcount;
        test_oneshot;
        test_reload;
        test_preset_update;
        test_decode;
`ifdef TIMER_PRESCALE_EN
        test_prescale;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer peripheral and source of one HWint line into the CP0 interrupt logic.
- Sits on the CPU-to-device bridge and is programmed by sw/lw to three word registers.
- Its `irq` output drives one bit of the 6-bit hardware-interrupt vector sampled by CP0 every cycle.
- Supports one-shot mode (level interrupt held until software rewrites CTRL) and auto-reload mode (one-cycle interrupt pulse per period).

Parameters:
- BASE_ADDR, 32'h0000_7F00, byte base address of the register block; bits [3:0] are 0.
- CNT_W, 32, width of PRESET/COUNT; values below 32 are zero-extended on read.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- addr  in  32  bus byte address; decoded when addr[31:4]==BASE_ADDR[31:4]; addr[3:2] selects the register
- we  in  1  bus write enable; only effective when the address hits this block
- wdata  in  32  bus write data
- rdata  out  32  combinational read data for addr; 0 on a miss or an unmapped offset
- irq  out  1  interrupt request to CP0 HWint

Behaviour:
- Registers:
  - 0x0 CTRL: bit0 En, bits[2:1] Mode (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM; other bits read 0.
  - 0x4 PRESET: read/write.
  - 0x8 COUNT: read-only; writes are ignored.
  - 0xC: reserved.
- Reset (reset low, asynchronous): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, irq=0.
- Writes commit at the clock edge. Reads are combinational from current register values.
- FSM transitions, per clock edge:
  - IDLE: if En, go to LOAD.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT, En==0: go to IDLE; COUNT is held.
  - CNT, COUNT>1: COUNT<=COUNT-1.
  - CNT, COUNT<=1: COUNT<=0; irq_flag<=1; go to INT.
  - INT, Mode one-shot: En<=0; go to IDLE; irq_flag stays 1.
  - INT, Mode auto-reload: irq_flag<=0; go to LOAD.
- Output: irq = irq_flag & IM, registered with no combinational path from the bus.
- Timing: with the CTRL write at edge E0 and PRESET=N≥1, LOAD is reached at E1, CNT with COUNT=N at E2, and INT/irq at E(N+2). The auto-reload period is N+2 cycles. PRESET=0 behaves like PRESET=1.
- irq_flag clears on any bus write to CTRL, including writes of the same value; this is the software acknowledge.
- Write to CTRL in the same edge as the INT hardware clear of En: the bus write wins for all CTRL bits, and irq_flag clears.
- Write to PRESET during CNT does not change COUNT; the new value is used at the next LOAD.
- Clearing En during INT in auto-reload mode: INT still goes to LOAD, then LOAD goes to CNT, then CNT goes to IDLE.
- COUNT never wraps below 0.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - Offset 0xC becomes PSC, 16-bit read/write, reset 0.
  - In CNT, COUNT decrements only when the prescaler tick fires, i.e. once every PSC+1 cycles.
  - The prescaler restarts in LOAD.
- Undefined: 0xC reads 0, ignores writes, and COUNT decrements every cycle.

Decomposition:
- Shared package timer_pkg holds:
  - state enum IDLE/LOAD/CNT/INT
  - register offset constants CTRL_OFF/PRESET_OFF/COUNT_OFF/PSC_OFF
  - Mode encodings MODE_ONESHOT/MODE_RELOAD
  - CTRL bit-index constants
- One sub-module, timer_prescaler: inputs clk, reset, restart, div[15:0]; output tick. Instantiated only under TIMER_PRESCALE_EN.

Test Plan:
- Reset mid-count: PRESET=100, En=1, assert reset low at cycle 20 → all registers read 0 immediately, irq=0, and after release the block stays in IDLE.
- One-shot:
  - Stimulus: PRESET=5, CTRL=0x9 written at E0.
  - Required: COUNT reads 5 after E2, 1 after E6, and irq rises after E7 and stays high.
  - Required: CTRL reads 0x8 after E8.
  - Then write CTRL=0x8 → irq falls at the next edge.
- Auto-reload:
  - Stimulus: PRESET=3, CTRL=0xB.
  - Required: irq is a 1-cycle pulse every 5 cycles for 4 periods.
  - Same with IM=0: COUNT still cycles 3..0 and irq stays 0.
- PRESET update during CNT: PRESET=10, run, write PRESET=2 at COUNT=6 in auto-reload → the first period is unchanged and the next period is 4 cycles.
- Bus decode:
  - Write COUNT=0xFFFF → COUNT is unaffected.
  - A write with addr=BASE_ADDR+0x10 → no register changes.
  - Reads of 0xC return 0, or PSC when TIMER_PRESCALE_EN is defined.
- Prescaler (TIMER_PRESCALE_EN): PSC=3, PRESET=2, one-shot → irq appears after 1+1+(2×4) edges, within ±1 tick alignment checked exactly against the model.
